patch_keypoint_collector: RTL

- Downstream of the bank of per-patch non-max-suppression units.
- During a frame, each unit's write strobe marks the current pixel as that patch's new best corner. This block latches score, row and col per patch ID.
- On frame end it drains all captured keypoints, in ascending ID order, over a valid/ready stream to the descriptor/output stage.

---
 rtl/patch_keypoint_collector.sv | 129 ++++++++++++
 1 files changed

// File: rtl/patch_keypoint_collector.sv
// Latches the latest {score,row,col} per patch ID during a frame, then drains the
// captured keypoints in ascending ID order over a valid/ready stream on frame end.
module patch_keypoint_collector #(
    parameter int NUM_PATCH = 64,
    parameter int ID_W      = 7,
    parameter int SCORE_W   = 15
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 pix_valid,
    input  logic [7:0]           row_cnt,
    input  logic [8:0]           col_cnt,
    input  logic [SCORE_W-1:0]   new_score,
    input  logic [NUM_PATCH-1:0] wr_en_vec,
    input  logic                 frame_end,
    output logic                 kp_valid,
    input  logic                 kp_ready,
    output logic [ID_W-1:0]      kp_id,
    output logic [SCORE_W-1:0]   kp_score,
    output logic [7:0]           kp_row,
    output logic [8:0]           kp_col,
    output logic                 frame_done,
    output logic [ID_W:0]        kp_count,
    output logic                 busy,
    output logic [15:0]          drop_cnt
);

    localparam int IDX_W = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATCH - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PATCH-1:0] valid_q, valid_d;
    logic [ID_W:0]        count_q, count_d;
    logic [15:0]          drop_q, drop_d;

    logic [SCORE_W-1:0]   score_q [NUM_PATCH];
    logic [7:0]           row_q   [NUM_PATCH];
    logic [8:0]           col_q   [NUM_PATCH];

    logic capture;
    logic strobe_any;

    assign busy       = (state_q != S_COLLECT);
    assign frame_done = (state_q == S_DONE);
    assign kp_valid   = (state_q == S_DRAIN) && valid_q[ptr_q];
    assign capture    = (state_q == S_COLLECT) && pix_valid;
    assign strobe_any = pix_valid && (|wr_en_vec);

    // Presented keypoint reads straight from the table; zero whenever nothing is offered.
    assign kp_id    = kp_valid ? ID_W'(ptr_q)   : '0;
    assign kp_score = kp_valid ? score_q[ptr_q] : '0;
    assign kp_row   = kp_valid ? row_q[ptr_q]   : '0;
    assign kp_col   = kp_valid ? col_q[ptr_q]   : '0;
    assign kp_count = count_q;
    assign drop_cnt = drop_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        count_d = count_q;
        drop_d  = drop_q;

        case (state_q)
            S_COLLECT: begin
                if (pix_valid) valid_d = valid_q | wr_en_vec;
                if (frame_end) begin
                    state_d = S_DRAIN;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            S_DRAIN: begin
                // Empty entries are skipped in one cycle; full ones wait for the handshake.
                if (!valid_q[ptr_q] || kp_ready) begin
                    if (valid_q[ptr_q]) begin
                        valid_d[ptr_q] = 1'b0;
                        count_d        = count_q + 1'b1;
                    end
                    if (ptr_q == LAST_IDX) state_d = S_DONE;
                    else                   ptr_d   = ptr_q + 1'b1;
                end
            end
            S_DONE: begin
                valid_d = '0;
                ptr_d   = '0;
                state_d = S_COLLECT;
            end
            default: state_d = S_COLLECT;
        endcase

        if (busy && strobe_any && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            state_q <= S_COLLECT;
            ptr_q   <= '0;
            valid_q <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // NOTE: the payload table has no reset; the valid bits alone decide what is meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PATCH; i++) begin
            if (capture && wr_en_vec[i]) begin
                score_q[i] <= new_score;
                row_q[i]   <= row_cnt;
                col_q[i]   <= col_cnt;
            end
        end
    end

endmodule
